// File: rtl/scan_scheduler.sv
// Scan sequencer for the 8-section multiplexed display/switch matrix: blank slot, drive slot,
// per-section switch sampling with debounce.
module scan_scheduler #(
    parameter int unsigned N_SECT      = 8,
    parameter int unsigned PRESCALE    = 2500,
    parameter int unsigned BLANK_TICKS = 1,
    parameter int unsigned DWELL_TICKS = 4,
    parameter int unsigned DEBOUNCE    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [3*N_SECT-1:0]   data_sections,
    input  logic                  data_switch,
    output logic [N_SECT-1:0]     selector,
    output logic [2:0]            data_output,
    output logic [2:0]            section,
    output logic [N_SECT-1:0]     switch_state,
    output logic                  switch_changed,
    output logic                  frame_done
);

    localparam int unsigned PRE_W    = $clog2(PRESCALE);
    localparam int unsigned SLOT_MAX = (BLANK_TICKS > DWELL_TICKS) ? BLANK_TICKS : DWELL_TICKS;
    localparam int unsigned SLOT_W   = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;
    localparam int unsigned DB_W     = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_DRIVE = 2'd2;

    localparam logic [2:0]        LAST_SECT  = 3'(N_SECT - 1);
    localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_TICKS - 1);
    localparam logic [SLOT_W-1:0] DWELL_LAST = SLOT_W'(DWELL_TICKS - 1);
    localparam logic [DB_W-1:0]   DB_LIMIT   = DB_W'(DEBOUNCE);

    logic [PRE_W-1:0]             pre_cnt;
    logic                         tick_c;
    logic [1:0]                   state, state_d;
    logic [SLOT_W-1:0]            slot_cnt, slot_d;
    logic [2:0]                   section_d;
    logic [N_SECT-1:0]            selector_d;
    logic [2:0]                   data_d;
    logic [2:0]                   sect_data_c;
    logic                         frame_done_d;
    logic                         sample_c;
    logic [N_SECT-1:0][DB_W-1:0]  db_cnt, db_cnt_d;
    logic [N_SECT-1:0]            switch_d;
    logic                         changed_d;

    assign tick_c      = enable && (pre_cnt == PRE_W'(PRESCALE - 1));
    assign sect_data_c = data_sections[32'(section) * 3 +: 3];

    // Scan-tick prescaler, parked at zero while scanning is stopped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 pre_cnt <= '0;
        else if (!enable || tick_c) pre_cnt <= '0;
        else                        pre_cnt <= pre_cnt + PRE_W'(1);
    end

    // Slot sequencing: next state and next registered outputs
    always_comb begin
        state_d      = state;
        slot_d       = slot_cnt;
        section_d    = section;
        selector_d   = selector;
        data_d       = data_output;
        frame_done_d = 1'b0;
        sample_c     = 1'b0;
        if (!enable) begin
            state_d    = S_IDLE;
            slot_d     = '0;
            section_d  = '0;
            selector_d = '0;
            data_d     = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    selector_d = '0;
                    data_d     = '0;
                    section_d  = '0;
                    if (tick_c) state_d = S_BLANK;
                end
                S_BLANK: begin
                    if (tick_c) begin
                        if (slot_cnt == BLANK_LAST) begin
                            slot_d     = '0;
                            state_d    = S_DRIVE;
                            selector_d = N_SECT'(1) << section;
                            data_d     = sect_data_c;
                        end else begin
                            slot_d = slot_cnt + SLOT_W'(1);
                        end
                    end
                end
                S_DRIVE: begin
                    data_d = sect_data_c;
                    if (tick_c) begin
                        if (slot_cnt == DWELL_LAST) begin
                            sample_c   = 1'b1;
                            slot_d     = '0;
                            selector_d = '0;
                            data_d     = '0;
                            state_d    = S_BLANK;
                            if (section == LAST_SECT) begin
                                section_d    = '0;
                                frame_done_d = 1'b1;
                            end else begin
                                section_d = section + 3'd1;
                            end
                        end else begin
                            slot_d = slot_cnt + SLOT_W'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Debounce only the section whose drive slot is ending
    always_comb begin
        switch_d  = switch_state;
        db_cnt_d  = db_cnt;
        changed_d = 1'b0;
        if (sample_c) begin
            if (data_switch == switch_state[section]) begin
                db_cnt_d[section] = '0;
            end else if (db_cnt[section] + DB_W'(1) == DB_LIMIT) begin
                switch_d[section] = ~switch_state[section];
                db_cnt_d[section] = '0;
                changed_d         = 1'b1;
            end else begin
                db_cnt_d[section] = db_cnt[section] + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            slot_cnt       <= '0;
            section        <= '0;
            selector       <= '0;
            data_output    <= '0;
            frame_done     <= 1'b0;
            switch_state   <= '0;
            db_cnt         <= '0;
            switch_changed <= 1'b0;
        end else begin
            state          <= state_d;
            slot_cnt       <= slot_d;
            section        <= section_d;
            selector       <= selector_d;
            data_output    <= data_d;
            frame_done     <= frame_done_d;
            switch_state   <= switch_d;
            db_cnt         <= db_cnt_d;
            switch_changed <= changed_d;
        end
    end

endmodule

// File: tb/tb_scan_scheduler.sv
// Bench for scan_scheduler: reference model derives the expected scan position from the
// number of enabled clocks since the last stop, plus per-section debounce bookkeeping.
module tb_scan_scheduler;

    localparam int N  = 8;
    localparam int P  = 4;
    localparam int B  = 1;
    localparam int D  = 2;
    localparam int DB = 3;
    localparam int BD = B + D;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [3*N-1:0] data_sections;
    logic          data_switch;
    logic [N-1:0]  selector;
    logic [2:0]    data_output;
    logic [2:0]    section;
    logic [N-1:0]  switch_state;
    logic          switch_changed;
    logic          frame_done;

    int tests = 0;
    int fails = 0;

    // reference model state
    int         n_en;
    logic [N-1:0] m_sw;
    int         m_cnt [N];
    logic [N-1:0] exp_sel;
    logic [2:0] exp_data;
    logic [2:0] exp_sect;
    logic       exp_changed;
    logic       exp_fd;

    scan_scheduler #(
        .N_SECT(N), .PRESCALE(P), .BLANK_TICKS(B), .DWELL_TICKS(D), .DEBOUNCE(DB)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .data_sections(data_sections),
        .data_switch(data_switch), .selector(selector), .data_output(data_output),
        .section(section), .switch_state(switch_state), .switch_changed(switch_changed),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        n_en = 0;
        m_sw = '0;
        for (int k = 0; k < N; k++) m_cnt[k] = 0;
        exp_sel = '0; exp_data = '0; exp_sect = '0; exp_changed = 1'b0; exp_fd = 1'b0;
    endtask

    // One clock: advance the model from the inputs present at the edge, then settle 1 time unit
    task automatic step();
        int t, s, ft;
        @(posedge clk);
        exp_changed = 1'b0;
        exp_fd      = 1'b0;
        if (!enable) begin
            n_en = 0;
        end else begin
            n_en++;
            t = n_en / P;
            if ((n_en % P == 0) && t > 1 && ((t - 1) % BD == 0)) begin
                s = ((t - 1) / BD - 1) % N;
                if (data_switch == m_sw[s]) m_cnt[s] = 0;
                else if (m_cnt[s] + 1 == DB) begin
                    m_sw[s] = ~m_sw[s]; m_cnt[s] = 0; exp_changed = 1'b1;
                end else m_cnt[s]++;
                exp_fd = (s == N - 1);
            end
        end
        t = n_en / P;
        exp_sel = '0; exp_data = '0; exp_sect = '0;
        if (t > 0) begin
            ft = (t - 1) % (N * BD);
            exp_sect = 3'(ft / BD);
            if (ft % BD >= B) begin
                exp_sel  = N'(1) << (ft / BD);
                exp_data = data_sections[3 * (ft / BD) +: 3];
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; enable = 1'b0; data_switch = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        data_sections = '0;
        do_reset();
        tests++; if (selector !== 8'h00) begin fails++; $display("FAIL reset_selector got %h want 00", selector); end
        tests++; if (data_output !== 3'd0) begin fails++; $display("FAIL reset_data got %0d want 0", data_output); end
        tests++; if (section !== 3'd0) begin fails++; $display("FAIL reset_section got %0d want 0", section); end
        tests++; if (switch_state !== 8'h00) begin fails++; $display("FAIL reset_switch got %h want 00", switch_state); end
        tests++; if (switch_changed !== 1'b0 || frame_done !== 1'b0) begin
            fails++; $display("FAIL reset_pulses got %b%b want 00", switch_changed, frame_done); end
    endtask

    task automatic test_scan();
        int fd_first, fd_count, sel_at8;
        fd_first = -1; fd_count = 0; sel_at8 = -1;
        for (int k = 0; k < N; k++) data_sections[3*k +: 3] = 3'(k);
        enable = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            step();
            if (c == 8) sel_at8 = int'(selector);
            if (frame_done === 1'b1) begin
                if (fd_first < 0) fd_first = c;
                else begin
                    tests++; if (c - fd_first != 96) begin fails++; $display("FAIL scan_frame_period got %0d want 96", c - fd_first); end
                end
                fd_count++;
            end
            if (selector !== exp_sel || data_output !== exp_data || section !== exp_sect || frame_done !== exp_fd) begin
                tests++; fails++;
                $display("FAIL scan_cycle%0d got sel=%h data=%0d sect=%0d fd=%b want sel=%h data=%0d sect=%0d fd=%b",
                         c, selector, data_output, section, frame_done, exp_sel, exp_data, exp_sect, exp_fd);
            end
            if ($countones(selector) > 1) begin
                tests++; fails++; $display("FAIL scan_onehot got %h want at most one bit", selector);
            end
        end
        tests++; if (sel_at8 != 1) begin fails++; $display("FAIL scan_first_drive got %h want 01", sel_at8); end
        tests++; if (fd_count != 2) begin fails++; $display("FAIL scan_frame_count got %0d want 2", fd_count); end
        tests++; if (fd_first != 100) begin fails++; $display("FAIL scan_first_frame got %0d want 100", fd_first); end
    endtask

    task automatic test_debounce();
        int pulses;
        pulses = 0;
        do_reset();
        enable = 1'b1;
        for (int c = 0; c < 300; c++) begin
            data_switch = exp_sel[3];
            step();
            if (switch_changed === 1'b1) pulses++;
            if (switch_state !== m_sw || switch_changed !== exp_changed) begin
                tests++; fails++;
                $display("FAIL debounce_cycle%0d got sw=%h chg=%b want sw=%h chg=%b", c, switch_state, switch_changed, m_sw, exp_changed);
            end
        end
        data_switch = 1'b0;
        tests++; if (switch_state !== 8'h08) begin fails++; $display("FAIL debounce_state got %h want 08", switch_state); end
        tests++; if (pulses != 1) begin fails++; $display("FAIL debounce_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_glitch();
        int pulses;
        pulses = 0;
        for (int c = 0; c < 3 * 96; c++) begin
            data_switch = (c < 2 * 96);
            step();
            if (switch_changed === 1'b1) pulses++;
            if (switch_state !== m_sw) begin
                tests++; fails++; $display("FAIL glitch_cycle%0d got sw=%h want sw=%h", c, switch_state, m_sw);
            end
        end
        data_switch = 1'b0;
        tests++; if (switch_state !== 8'h08) begin fails++; $display("FAIL glitch_state got %h want 08", switch_state); end
        tests++; if (pulses != 0) begin fails++; $display("FAIL glitch_pulses got %0d want 0", pulses); end
    endtask

    task automatic test_disable();
        int budget, wait_c;
        logic [N-1:0] saved;
        budget = 0;
        while (exp_sel !== 8'h20 && budget < 200) begin step(); budget++; end
        tests++; if (selector !== 8'h20) begin fails++; $display("FAIL disable_reach_s5 got %h want 20", selector); end
        saved = switch_state;
        enable = 1'b0;
        step();
        tests++; if (selector !== 8'h00 || section !== 3'd0) begin
            fails++; $display("FAIL disable_stop got sel=%h sect=%0d want sel=00 sect=0", selector, section); end
        repeat (5) step();
        enable = 1'b1;
        wait_c = 0;
        while (selector === 8'h00 && wait_c < 50) begin step(); wait_c++; end
        tests++; if (wait_c != 8) begin fails++; $display("FAIL disable_restart_delay got %0d want 8", wait_c); end
        tests++; if (selector !== 8'h01 || section !== 3'd0) begin
            fails++; $display("FAIL disable_restart got sel=%h sect=%0d want sel=01 sect=0", selector, section); end
        tests++; if (switch_state !== saved || saved !== 8'h08) begin
            fails++; $display("FAIL disable_keep_switch got %h want 08", switch_state); end
    endtask

    task automatic test_data_follow();
        int budget;
        budget = 0;
        while (exp_sel !== 8'h01 && budget < 200) begin step(); budget++; end
        tests++; if (data_output !== 3'd0) begin fails++; $display("FAIL follow_before got %0d want 0", data_output); end
        data_sections[2:0] = 3'd5;
        step();
        tests++; if (data_output !== 3'd5 || selector !== 8'h01) begin
            fails++; $display("FAIL follow_after got data=%0d sel=%h want data=5 sel=01", data_output, selector); end
        data_sections[2:0] = 3'd0;
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int c = 0; c < 1500; c++) begin
            data_switch = 1'($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 15) == 0) data_sections = 24'($urandom);
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            else if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
            step();
            tests++;
            if (selector !== exp_sel || data_output !== exp_data || section !== exp_sect ||
                frame_done !== exp_fd || switch_state !== m_sw || switch_changed !== exp_changed) begin
                fails++; bad++;
                if (bad < 10)
                    $display("FAIL random_cycle%0d got sel=%h d=%0d s=%0d fd=%b sw=%h chg=%b want sel=%h d=%0d s=%0d fd=%b sw=%h chg=%b",
                             c, selector, data_output, section, frame_done, switch_state, switch_changed,
                             exp_sel, exp_data, exp_sect, exp_fd, m_sw, exp_changed);
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_async_reset();
        int budget;
        budget = 0;
        while (exp_sel === 8'h00 && budget < 200) begin step(); budget++; end
        #2 reset = 1'b0;
        #1;
        tests++; if (selector !== 8'h00 || data_output !== 3'd0 || section !== 3'd0) begin
            fails++; $display("FAIL async_reset_outputs got sel=%h d=%0d s=%0d want 0", selector, data_output, section); end
        tests++; if (switch_state !== 8'h00 || switch_changed !== 1'b0 || frame_done !== 1'b0) begin
            fails++; $display("FAIL async_reset_switch got sw=%h want 00", switch_state); end
        model_clear();
        @(negedge clk) reset = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            step();
            tests++;
            if (selector !== exp_sel || section !== exp_sect || data_output !== exp_data) begin
                fails++; $display("FAIL async_restart_cycle%0d got sel=%h want %h", c, selector, exp_sel);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_debounce();
        test_glitch();
        test_disable();
        test_data_follow();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
